// File: rtl/apb_slave_pkg.sv
// Shared constants for the APB register slave: state encoding, register offsets
// and the CTRL.WAIT field width.
package apb_slave_pkg;

    localparam int WAIT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_READY = 2'd2;

    localparam logic [5:0] OFF_CTRL   = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;

endpackage

// File: rtl/apb_reg_slave_regs.sv
// Register storage for the APB slave: CTRL.WAIT, STATUS counters and the
// general-purpose registers.
module apb_reg_slave_regs
    import apb_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  commit,
    input  logic                  err_inc,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      reg_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [WAIT_W-1:0]     ctrl_wait
);

    // Sized to a power of two so any index value is in range; entries at or
    // above NUM_REGS are never written because the top flags them as errors.
    logic [DATA_WIDTH-1:0] gp_regs [2**IDX_W];
    logic [15:0]           err_cnt;
    logic [15:0]           xfer_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_wait <= '0;
            err_cnt   <= '0;
            xfer_cnt  <= '0;
            for (int i = 0; i < 2**IDX_W; i++) begin
                gp_regs[i] <= '0;
            end
        end else begin
            if (commit) begin
                xfer_cnt <= xfer_cnt + 16'd1;
                if (err_inc && err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            if (wr_en) begin
                if (reg_idx == IDX_W'(OFF_CTRL)) begin
                    ctrl_wait <= wr_data[WAIT_W-1:0];
                end else if (reg_idx != IDX_W'(OFF_STATUS)) begin
                    gp_regs[reg_idx] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (reg_idx == IDX_W'(OFF_CTRL)) begin
            rd_data = DATA_WIDTH'(ctrl_wait);
        end else if (reg_idx == IDX_W'(OFF_STATUS)) begin
            rd_data = DATA_WIDTH'({xfer_cnt, err_cnt});
        end else begin
            rd_data = gp_regs[reg_idx];
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: transfer FSM with programmable wait states, address
// decode / error detection, and the register file instance.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h300,
    parameter int                    NUM_REGS   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REGS);

    state_t                state;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     ctrl_wait;
    logic [ADDR_WIDTH-1:0] addr_off;
    logic [5:0]            word_idx;
    logic                  addr_err;
    logic                  ready;
    logic                  commit;
    logic [DATA_WIDTH-1:0] reg_rd_data;

    assign addr_off = lat_addr - BASE_ADDR;
    assign word_idx = addr_off[7:2];
    assign addr_err = (lat_addr < BASE_ADDR)
                   || (addr_off > ADDR_WIDTH'(255))
                   || (lat_addr[1:0] != 2'b00)
                   || ({1'b0, word_idx} >= 7'(NUM_REGS))
                   || (lat_write && word_idx == OFF_STATUS);

    assign ready   = (state == ST_READY);
    assign commit  = ready && PSEL && PENABLE;
    assign PREADY  = ready;
    assign PSLVERR = ready && addr_err;
    assign PRDATA  = (ready && !lat_write && !addr_err) ? reg_rd_data : '0;

    // Counter holds the WAIT value latched at setup, so CTRL updates only
    // affect later transfers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        lat_addr  <= PADDR;
                        lat_write <= PWRITE;
                        lat_wdata <= PWDATA;
                        wait_cnt  <= ctrl_wait;
                        state     <= (ctrl_wait == '0) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_W'(1)) begin
                        state <= ST_READY;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_READY: begin
                    if (!PSEL || PENABLE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    apb_reg_slave_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regs (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .commit    (commit),
        .err_inc   (addr_err),
        .wr_en     (commit && lat_write && !addr_err),
        .reg_idx   (word_idx[IDX_W-1:0]),
        .wr_data   (lat_wdata),
        .rd_data   (reg_rd_data),
        .ctrl_wait (ctrl_wait)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: directed scenarios followed by random
// transfers compared against a register-map model.
module tb_apb_reg_slave;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    // Reference model of the register map.
    logic [31:0] m_gp [16];
    logic [3:0]  m_ctrl;
    int          m_err;
    int          m_xfer;

    apb_reg_slave dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gp[i] = 32'h0;
        m_ctrl = 4'h0;
        m_err  = 0;
        m_xfer = 0;
    endtask

    function automatic bit exp_err(input logic [31:0] a, input bit wr);
        int off;
        if (a < 32'h300 || a >= 32'h400) return 1'b1;
        if (a % 4 != 0) return 1'b1;
        off = int'((a - 32'h300) / 4);
        if (off >= 16) return 1'b1;
        if (wr && off == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int off;
        off = int'((a - 32'h300) / 4);
        if (off == 0) return {28'h0, m_ctrl};
        if (off == 1) return {m_xfer[15:0], m_err[15:0]};
        return m_gp[off];
    endfunction

    // Entered at #1 after a rising edge; leaves at #1 after the commit edge
    // with PSEL low, so a following call is back-to-back.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd, input string tag);
        bit          eerr;
        logic [31:0] erd;
        int          ewait;
        int          cycles;
        bit          got;
        int          off;
        eerr  = exp_err(addr, wr);
        erd   = (eerr || wr) ? 32'h0 : exp_rd(addr);
        ewait = int'(m_ctrl);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge PCLK);
            cycles++;
            if (PREADY === 1'b1) got = 1'b1;
            else begin
                @(posedge PCLK); #1;
            end
        end
        chk({tag, " ready"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(cycles), 32'(ewait + 1));
        chk({tag, " pslverr"}, 32'(PSLVERR), 32'(eerr));
        chk({tag, " prdata"}, PRDATA, erd);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk({tag, " pready_after"}, 32'(PREADY), 32'd0);
        chk({tag, " prdata_after"}, PRDATA, 32'h0);
        if (got) begin
            m_xfer = (m_xfer + 1) % 65536;
            if (eerr) begin
                if (m_err < 65535) m_err = m_err + 1;
            end else if (wr) begin
                off = int'((addr - 32'h300) / 4);
                if (off == 0) m_ctrl = wd[3:0];
                else m_gp[off] = wd;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        int          r;
        model_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        PADDR = '0; PWRITE = 1'b0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset pready", 32'(PREADY), 32'd0);
        chk("reset pslverr", 32'(PSLVERR), 32'd0);
        chk("reset prdata", PRDATA, 32'h0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Access phase with no preceding setup is ignored.
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h308; PWRITE = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            chk("no_setup pready", 32'(PREADY), 32'd0);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;

        xfer(32'h308, 1'b1, 32'hDEADBEEF, "w308");
        xfer(32'h308, 1'b0, 32'h0, "r308");

        xfer(32'h300, 1'b1, 32'h0000_0003, "ctrl3");
        xfer(32'h308, 1'b0, 32'h0, "r308_wait3");
        xfer(32'h300, 1'b0, 32'h0, "rctrl");

        xfer(32'h304, 1'b1, 32'hFFFF_FFFF, "w_status");
        xfer(32'h30A, 1'b0, 32'h0, "misalign");
        xfer(32'h340, 1'b0, 32'h0, "beyond");
        xfer(32'h304, 1'b0, 32'h0, "rstatus");

        // Abort mid-wait: no commit, no storage or counter change.
        xfer(32'h300, 1'b1, 32'h0000_0005, "ctrl5");
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h30C; PWRITE = 1'b1; PWDATA = 32'h1234_5678;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) begin
            @(negedge PCLK);
            chk("abort pready_low", 32'(PREADY), 32'd0);
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk("abort pready_after", 32'(PREADY), 32'd0);
        xfer(32'h30C, 1'b0, 32'h0, "r30c_after_abort");
        xfer(32'h304, 1'b0, 32'h0, "rstatus_after_abort");

        // Reset in the middle of a waited write.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h310; PWRITE = 1'b1; PWDATA = $urandom;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("midreset pready", 32'(PREADY), 32'd0);
        chk("midreset pslverr", 32'(PSLVERR), 32'd0);
        chk("midreset prdata", PRDATA, 32'h0);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        @(posedge PCLK); #1;
        xfer(32'h310, 1'b0, 32'h0, "r310_after_reset");
        xfer(32'h300, 1'b0, 32'h0, "rctrl_after_reset");

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'h300 + 4 * $urandom_range(0, 15);
            else if (r == 7) a = 32'h300 + $urandom_range(0, 255);
            else if (r == 8) a = 32'h340 + 4 * $urandom_range(0, 47);
            else             a = ($urandom_range(0, 1) == 0) ? 32'h2FC : 32'h400 + 4 * $urandom_range(0, 63);
            w = 1'($urandom_range(0, 1));
            xfer(a, w, $urandom, "rand");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
            end
        end
        xfer(32'h304, 1'b0, 32'h0, "rstatus_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PADDR width.
REQ-002 Parameter DATA_WIDTH, default 32, PWDATA/PRDATA width.
REQ-003 Parameter BASE_ADDR, default 32'h300, first byte address of this slave's 256-byte window.
REQ-004 Parameter NUM_REGS, default 16, number of 32-bit registers (range 3..64).
REQ-005 Clocking and reset are decided: one clock; reset is synchronous and active-high.
REQ-006 PCLK  input  1  clock; all logic on rising edge.
REQ-007 PRESET  input  1  synchronous active-high reset.
REQ-008 PSEL  input  1  slave select from bridge.
REQ-009 PENABLE  input  1  access-phase indicator.
REQ-010 PADDR  input  ADDR_WIDTH  byte address.
REQ-011 PWRITE  input  1  1 = write, 0 = read.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PRDATA  output  DATA_WIDTH  read data, valid only while PREADY=1.
REQ-014 PREADY  output  1  registered transfer-complete.
REQ-015 PSLVERR  output  1  error, valid only while PREADY=1.

Function
REQ-016 Register map (word offset = (PADDR-BASE_ADDR)>>2): 0 = CTRL, RW, bits[3:0] WAIT, other bits read 0; 1 = STATUS, RO, [15:0] error count saturating at 16'hFFFF, [31:16] completed-transfer count wrapping mod 2^16; 2..NUM_REGS-1 = general RW.
REQ-017 FSM states: IDLE, WAIT, READY.
REQ-018 IDLE: PSEL=1 & PENABLE=0 (setup) -> latch PADDR/PWRITE/PWDATA, load counter with CTRL.WAIT, go WAIT if WAIT>0, else READY; PENABLE=1 without prior setup -> ignored, stay IDLE.
REQ-019 WAIT: counter decrements each cycle; at counter==1 go READY; access phase therefore lasts WAIT+1 cycles.
REQ-020 READY: PREADY=1; at the edge where PSEL&PENABLE=1 the transfer commits and FSM returns to IDLE; PREADY=0 the following cycle.
REQ-021 Back-to-back: setup presented in the cycle after completion is accepted from IDLE with no dead cycle.
REQ-022 Error (PSLVERR=1 with PREADY) when: address outside window, PADDR[1:0]!=0, offset >= NUM_REGS, or write to STATUS.
REQ-023 Errored write never modifies storage; errored read returns PRDATA=0.
REQ-024 PRDATA = 0 whenever PREADY=0.
REQ-025 On commit: transfer count +1 (wrap 16'hFFFF->0); on errored commit, error count +1 (saturate).
REQ-026 CTRL.WAIT change takes effect from the next setup; the in-flight transfer keeps its latched count.
REQ-027 Abort: PSEL=0 in WAIT or READY -> IDLE, no commit, no counter update, PREADY=0 next cycle.

Reset
REQ-028 PRESET=1 at an edge -> FSM IDLE, PREADY=0, PSLVERR=0, PRDATA=0, all registers and counters 0 (CTRL.WAIT=0).
REQ-029 Reset mid-transfer abandons it with no commit; first setup after reset release is accepted normally.

Structure
REQ-030 Package apb_slave_pkg holds the state enum, CTRL/STATUS offset constants and WAIT field width.
REQ-031 Storage and STATUS counters go in sub-module apb_reg_slave_regs; FSM, decode and wait counter in the top.

Verification
REQ-032 Write 32'hDEADBEEF to 0x308 (WAIT=0), then read 0x308 -> each PREADY in first access cycle, PSLVERR=0, PRDATA=32'hDEADBEEF.
REQ-033 Write 32'h0000_0003 to 0x300, then read 0x308 -> PREADY rises in 4th access cycle, PRDATA=32'hDEADBEEF; read 0x300 -> 32'h0000_0003.
REQ-034 Write 0x304, access 0x30A, access 0x340 (NUM_REGS=16) -> PSLVERR=1 each, read PRDATA=0, STATUS[15:0]=3, no storage change.
REQ-035 WAIT=5, write 32'h1234_5678 to 0x30C, drop PSEL after 2 access cycles -> no PREADY, later read 0x30C = 0, STATUS[31:16] unchanged.
REQ-036 Assert PRESET during WAIT of write to 0x310 -> outputs 0 next cycle, 0x310 reads 0, CTRL reads 0.
